acc_alu_pipe: RTL and testbench
===============================

Name: acc_alu_pipe

Overview:
- Parametrised successor to the combinational ui_in + uio_in adder in the Tiny Tapeout top.
- Registered add/sub/accumulate unit with valid/ready handshakes on input and output, a persistent accumulator, and status flags.
- Sits between the top-level pin mapping and the output pins. The top wires operands from ui_in/uio_in and mode/handshake bits from spare pins.

Parameters:
WIDTH, 8, operand width in bits (>=2)
ACC_WIDTH, 16, accumulator and result width (must be >= WIDTH+1)
CNT_WIDTH, 8, width of accepted-transaction counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
in_a  input  WIDTH  operand A (unsigned)
in_b  input  WIDTH  operand B (unsigned; ignored in modes 2/3)
in_mode  input  2  0=ADD, 1=SUB, 2=ACC wrap, 3=ACC saturate
acc_clear  input  1  synchronous accumulator clear request
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  downstream consumes result
out_data  output  ACC_WIDTH  result
out_carry  output  1  carry/borrow/wrap flag for the result
out_sat  output  1  saturation occurred (mode 3 only)
acc_value  output  ACC_WIDTH  live accumulator contents
txn_count  output  CNT_WIDTH  number of accepted beats, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async, rst=1): acc, out_data, out_carry, out_sat, out_valid and txn_count all 0. While rst is high, in_ready=0. Reset mid-transaction discards any pending result.
- in_ready = !rst && (!out_valid || out_ready). This gives single-register full throughput; the path is combinational from out_ready.
- Accept = in_valid && in_ready. On accept, the result register loads next edge, out_valid<=1, and txn_count increments. Latency is 1 cycle.
- out_valid && out_ready && no accept: out_valid<=0 and out_data holds its stale value.
- out_valid && !out_ready: out_data and flags are held stable; in_ready=0.
- ADD: s = a+b in WIDTH+1 bits. out_data = zero-extended s. out_carry = s[WIDTH]. out_sat = 0. acc unchanged.
- SUB: d = (a-b) mod 2^WIDTH, zero-extended. out_carry = 1 if a<b (borrow). out_sat = 0. acc unchanged.
- ACC wrap: base = acc_clear ? 0 : acc. acc <= (base + zext(a)) mod 2^ACC_WIDTH. out_data = new acc. out_carry = 1 if the add wrapped. out_sat = 0.
- ACC saturate: same base. If base + zext(a) > 2^ACC_WIDTH-1, then acc <= all-ones, out_sat=1, out_carry=0. Otherwise it is a plain add and out_sat=0.
- acc_clear without an ACC-mode accept: acc<=0 next edge. The result register, out_valid and txn_count are unaffected.
- acc_clear with an ADD/SUB accept: acc<=0 and the ADD/SUB result is produced normally.
- Once saturated, acc stays at all-ones for further mode-3 beats with out_sat=1 each time. Adding a=0 to a saturated acc gives out_sat=0.
- acc_value reflects the registered acc and updates on the same edge as out_data.
- txn_count wraps from all-ones to 0 without a flag.
- in_mode, in_a and in_b are sampled only on accept.

Test Plan:
- Reset then ADD a=200, b=100 (WIDTH=8) -> next cycle out_valid=1, out_data=300 (0x012C), out_carry=1, txn_count=1.
- SUB a=5, b=7 -> out_data=254, out_carry=1. SUB a=7, b=5 -> out_data=2, out_carry=0.
- ACC wrap: preload acc=0xFFF0 via repeated beats, then a=0x20 -> out_data=0x0010, out_carry=1. Repeat in mode 3 from 0xFFF0 -> out_data=0xFFFF, out_sat=1. Next mode-3 beat with a=1 -> 0xFFFF, out_sat=1.
- Backpressure: hold out_ready=0 after one ADD -> in_ready=0 and out_data stable for 5 cycles. Release with in_valid held -> back-to-back results one per cycle, no beat lost or duplicated (txn_count matches the beats sent).
- acc_clear together with ACC a=9 while acc=50 -> out_data=9, acc_value=9. acc_clear alone while out_valid=1 and stalled -> acc_value=0, out_data unchanged.
- Assert rst asynchronously mid-stall (between edges) -> out_valid, acc_value and txn_count go to 0 immediately and in_ready=0. After release, the first accepted ADD 1+1 -> out_data=2.

Source files
------------

// File: rtl/acc_alu_pipe.sv
// Registered add/sub/accumulate unit with valid/ready handshakes on both sides,
// a persistent accumulator with wrap or saturate modes, and an accepted-beat counter.
module acc_alu_pipe #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 16,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [1:0]           in_mode,
   input  logic                 acc_clear,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic                 out_carry,
   output logic                 out_sat,
   output logic [ACC_WIDTH-1:0] acc_value,
   output logic [CNT_WIDTH-1:0] txn_count
);

   localparam int AW1 = ACC_WIDTH + 1;
   localparam logic [1:0] MODE_ADD = 2'd0;
   localparam logic [1:0] MODE_SUB = 2'd1;
   localparam logic [1:0] MODE_ACC = 2'd2;
   localparam logic [1:0] MODE_SAT = 2'd3;

   logic                 out_valid_q, out_valid_d;
   logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
   logic                 out_carry_q, out_carry_d;
   logic                 out_sat_q, out_sat_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0] txn_q, txn_d;

   logic                 accept;
   logic [WIDTH:0]       add_s;
   logic [WIDTH-1:0]     sub_d;
   logic [ACC_WIDTH-1:0] acc_base;
   logic [ACC_WIDTH:0]   acc_sum;
   logic [ACC_WIDTH-1:0] res_data;
   logic                 res_carry;
   logic                 res_sat;

   always_comb begin
      // Single result register: a new beat may enter whenever the current one leaves.
      in_ready  = !rst && (!out_valid_q || out_ready);
      accept    = in_valid && in_ready;
      add_s     = {1'b0, in_a} + {1'b0, in_b};
      sub_d     = in_a - in_b;
      acc_base  = acc_clear ? '0 : acc_q;
      acc_sum   = AW1'(acc_base) + AW1'(in_a);

      res_data  = out_data_q;
      res_carry = 1'b0;
      res_sat   = 1'b0;
      case (in_mode)
         MODE_ADD: begin
            res_data  = ACC_WIDTH'(add_s);
            res_carry = add_s[WIDTH];
         end
         MODE_SUB: begin
            res_data  = ACC_WIDTH'(sub_d);
            res_carry = (in_a < in_b);
         end
         MODE_ACC: begin
            res_data  = acc_sum[ACC_WIDTH-1:0];
            res_carry = acc_sum[ACC_WIDTH];
         end
         MODE_SAT: begin
            if (acc_sum[ACC_WIDTH]) begin
               res_data = '1;
               res_sat  = 1'b1;
            end else begin
               res_data = acc_sum[ACC_WIDTH-1:0];
            end
         end
         default: ;
      endcase

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_carry_d = out_carry_q;
      out_sat_d   = out_sat_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = res_data;
         out_carry_d = res_carry;
         out_sat_d   = res_sat;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // A clear still applies when the accepted beat is ADD/SUB.
      acc_d = acc_q;
      if (accept && in_mode[1]) begin
         acc_d = res_data;
      end else if (acc_clear) begin
         acc_d = '0;
      end

      txn_d = txn_q + CNT_WIDTH'(accept);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_carry_q <= 1'b0;
         out_sat_q   <= 1'b0;
         acc_q       <= '0;
         txn_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_carry_q <= out_carry_d;
         out_sat_q   <= out_sat_d;
         acc_q       <= acc_d;
         txn_q       <= txn_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_carry = out_carry_q;
   assign out_sat   = out_sat_q;
   assign acc_value = acc_q;
   assign txn_count = txn_q;

endmodule

// File: tb/tb_acc_alu_pipe.sv
// Scoreboard bench for acc_alu_pipe: stimulus pushes expected results, a monitor
// pops and compares each result as it is consumed at the output handshake.
module tb_acc_alu_pipe;

   localparam int W  = 8;
   localparam int AW = 16;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [1:0]    in_mode;
   logic          acc_clear;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_data;
   logic          out_carry;
   logic          out_sat;
   logic [AW-1:0] acc_value;
   logic [CW-1:0] txn_count;

   acc_alu_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mode   (in_mode),
      .acc_clear (acc_clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_carry (out_carry),
      .out_sat   (out_sat),
      .acc_value (acc_value),
      .txn_count (txn_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] d;
      logic          c;
      logic          s;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int            errors = 0;
   int            checks = 0;
   logic [AW-1:0] macc;
   logic [CW-1:0] exp_txn;
   logic [16:0]   psum;
   logic [AW-1:0] held;
   int            idx;
   int            cyc;
   bit            took;
   logic [7:0]    va[4] = '{8'd1, 8'd10, 8'd128, 8'd255};
   logic [7:0]    vb[4] = '{8'd2, 8'd20, 8'd128, 8'd1};
   logic [15:0]   vd[4] = '{16'd3, 16'd30, 16'h0100, 16'h0100};
   logic          vc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] ed, input logic ec, input logic es);
      exp_t e;
      e.d = ed;
      e.c = ec;
      e.s = es;
      sb.push_back(e);
   endtask

   task automatic beat(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                       input logic clr, input logic [15:0] ed, input logic ec, input logic es);
      bit done;
      done      = 1'b0;
      in_valid  = 1'b1;
      in_mode   = m;
      in_a      = a;
      in_b      = b;
      acc_clear = clr;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            push(ed, ec, es);
            exp_txn++;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      acc_clear = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: in_ready stayed 0, expected a beat accepted within 20 cycles");
      end
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (!out_valid) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: out_valid stayed 1, expected 0 within 20 cycles");
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL result_unexpected: got data=%0h with no result expected", out_data);
         end else begin
            mon_e = sb.pop_front();
            if ({out_data, out_carry, out_sat} !== {mon_e.d, mon_e.c, mon_e.s}) begin
               errors++;
               $display("FAIL result: got data=%0h carry=%0b sat=%0b expected data=%0h carry=%0b sat=%0b",
                        out_data, out_carry, out_sat, mon_e.d, mon_e.c, mon_e.s);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_mode   = 2'd0;
      acc_clear = 1'b0;
      out_ready = 1'b1;
      macc      = '0;
      exp_txn   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_acc", acc_value, 0);
      chk("reset_txn", txn_count, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      beat(2'd0, 8'd200, 8'd100, 1'b0, 16'h012C, 1'b1, 1'b0);
      chk("add_out_valid", out_valid, 1);
      chk("add_txn", txn_count, 1);
      beat(2'd1, 8'd5, 8'd7, 1'b0, 16'd254, 1'b1, 1'b0);
      beat(2'd1, 8'd7, 8'd5, 1'b0, 16'd2, 1'b0, 1'b0);
      beat(2'd0, 8'd255, 8'd255, 1'b0, 16'd510, 1'b1, 1'b0);
      beat(2'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0, 1'b0);
      chk("addsub_acc_untouched", acc_value, 0);

      // Preload accumulator to 0xFFF0 with wrap-mode beats; txn_count wraps along the way.
      for (int i = 0; i < 256; i++) begin
         psum = {1'b0, macc} + 17'd255;
         beat(2'd2, 8'd255, 8'd0, 1'b0, psum[15:0], psum[16], 1'b0);
         macc = psum[15:0];
      end
      beat(2'd2, 8'hF0, 8'd0, 1'b0, 16'hFFF0, 1'b0, 1'b0);
      chk("preload_acc", acc_value, 16'hFFF0);
      chk("txn_wrap", txn_count, exp_txn);
      beat(2'd2, 8'h20, 8'd0, 1'b0, 16'h0010, 1'b1, 1'b0);
      chk("wrap_acc", acc_value, 16'h0010);
      macc = 16'h0010;

      for (int i = 0; i < 256; i++) begin
         psum = {1'b0, macc} + 17'd255;
         beat(2'd2, 8'd255, 8'd0, 1'b0, psum[15:0], psum[16], 1'b0);
         macc = psum[15:0];
      end
      beat(2'd2, 8'hE0, 8'd0, 1'b0, 16'hFFF0, 1'b0, 1'b0);
      beat(2'd3, 8'h20, 8'd0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
      beat(2'd3, 8'h01, 8'd0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
      beat(2'd3, 8'h00, 8'd0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
      chk("sat_acc", acc_value, 16'hFFFF);

      beat(2'd2, 8'd50, 8'd0, 1'b1, 16'd50, 1'b0, 1'b0);
      beat(2'd2, 8'd9, 8'd0, 1'b1, 16'd9, 1'b0, 1'b0);
      chk("clear_acc_beat", acc_value, 9);
      beat(2'd3, 8'd5, 8'd0, 1'b0, 16'd14, 1'b0, 1'b0);
      beat(2'd0, 8'd1, 8'd2, 1'b1, 16'd3, 1'b0, 1'b0);
      chk("clear_with_add", acc_value, 0);
      beat(2'd2, 8'd14, 8'd0, 1'b0, 16'd14, 1'b0, 1'b0);

      // Backpressure: stall one result, hold the next beat pending, then release.
      drain();
      out_ready = 1'b0;
      beat(2'd0, 8'd3, 8'd4, 1'b0, 16'd7, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_mode  = 2'd0;
      in_a     = va[0];
      in_b     = vb[0];
      held     = out_data;
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_data", out_data, 7);
         chk("stall_out_valid", out_valid, 1);
      end
      chk("stall_txn", txn_count, exp_txn);
      @(posedge clk);
      #1;
      acc_clear = 1'b1;
      @(posedge clk);
      #1;
      acc_clear = 1'b0;
      chk("stall_clear_acc", acc_value, 0);
      chk("stall_clear_data", out_data, held);
      chk("stall_clear_valid", out_valid, 1);

      out_ready = 1'b1;
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 20) begin
         @(negedge clk);
         took = in_ready;
         if (took) push(vd[idx], vc[idx], 1'b0);
         @(posedge clk);
         #1;
         cyc++;
         if (took) begin
            idx++;
            exp_txn++;
            if (idx < 4) begin
               in_a = va[idx];
               in_b = vb[idx];
            end
         end
      end
      in_valid = 1'b0;
      chk("stream_cycles", cyc, 4);
      chk("stream_txn", txn_count, exp_txn);

      beat(2'd2, 8'd7, 8'd0, 1'b0, 16'd7, 1'b0, 1'b0);

      // Asynchronous reset between edges while a result is stalled.
      drain();
      out_ready = 1'b0;
      beat(2'd0, 8'd9, 8'd9, 1'b0, 16'd18, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_acc", acc_value, 0);
      chk("arst_txn", txn_count, 0);
      chk("arst_in_ready", in_ready, 0);
      chk("arst_out_data", out_data, 0);
      sb.delete();
      exp_txn = '0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      beat(2'd0, 8'd1, 8'd1, 1'b0, 16'd2, 1'b0, 1'b0);
      chk("post_reset_txn", txn_count, 1);
      drain();

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      chk("scoreboard_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
